// File: rtl/timer_pkg.sv
// Shared constants for the countdown-timer display path: active-high segment
// glyphs, digit count and scan index width, and the blink phase encoding.
package timer_pkg;

    localparam int DIGITS = 4;
    localparam int IDX_W  = 2;

    // Glyphs are {g,f,e,d,c,b,a}, 1 = segment lit.
    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    // Blink phase: visible shows the scan, hidden forces every pin inactive.
    typedef enum logic {
        PH_VISIBLE = 1'b0,
        PH_HIDDEN  = 1'b1
    } phase_t;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to 7-segment decoder (active-high). Codes 10-15 show a
// dash so a glitching counter is visible rather than blank.
module bcd_to_7seg
    import timer_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Glyph lookup; every code maps to a defined pattern, never X.
    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/timer_display_scan.sv
// Multiplexed 4-digit 7-segment driver for the MM:SS countdown timer.
// Scans one digit per DIV-cycle slot from a whole-frame snapshot of the
// counter outputs, with colon, leading-zero blanking and whole-display blink.
//
// Handshake note: there is no valid/ready pair here. The digit inputs are
// level signals sampled only at a snapshot; frame is a one-cycle strobe that
// marks the cycle in which the snapshot register loads.
module timer_display_scan
    import timer_pkg::*;
#(
    parameter int unsigned DIV          = 50000,
    parameter int unsigned BLINK_FRAMES = 64,
    parameter bit          ACTIVE_LOW   = 1'b1,
    parameter bit          BLANK_LZ     = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] dig0,
    input  logic [3:0] dig1,
    input  logic [3:0] dig2,
    input  logic [3:0] dig3,
    input  logic       colon_en,
    input  logic       blink,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       frame
);

    localparam int unsigned CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int unsigned BF_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DIV - 1);
    localparam logic [BF_W-1:0]  BF_MAX   = BF_W'(BLINK_FRAMES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic             tick;
    logic             capture;
    logic             load_pend;
    logic [3:0]       snap [DIGITS];

    phase_t           phase_q, phase_d;
    logic [BF_W-1:0]  bcnt_q, bcnt_d;
    logic             hide;

    logic [3:0]       cur_digit;
    logic [6:0]       dec_seg;
    logic             blank;
    logic [6:0]       seg_ah;
    logic [3:0]       an_ah;
    logic             dp_ah;

    assign tick    = (cnt == CNT_MAX);
    assign capture = load_pend | (tick & (idx == IDX_LAST));
    assign frame   = capture & ~reset;

    // Slot prescaler and scan index: idx moves on once per DIV cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + CNT_W'(1);
            if (tick) begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

    // Whole-frame snapshot so a borrow rippling through the counters never tears the display.
    always_ff @(posedge clock) begin
        if (reset) begin
            load_pend <= 1'b1;
            for (int i = 0; i < DIGITS; i++) begin
                snap[i] <= 4'd0;
            end
        end else if (capture) begin
            load_pend <= 1'b0;
            snap[0]   <= dig0;
            snap[1]   <= dig1;
            snap[2]   <= dig2;
            snap[3]   <= dig3;
        end
    end

    // Blink phase register.
    always_ff @(posedge clock) begin
        if (reset) begin
            phase_q <= PH_VISIBLE;
            bcnt_q  <= '0;
        end else begin
            phase_q <= phase_d;
            bcnt_q  <= bcnt_d;
        end
    end

    // Blink next state: count frames while blinking, flip phase every BLINK_FRAMES frames.
    always_comb begin
        phase_d = phase_q;
        bcnt_d  = bcnt_q;
        if (!blink) begin
            phase_d = PH_VISIBLE;
            bcnt_d  = '0;
        end else if (capture) begin
            if (bcnt_q == BF_MAX) begin
                bcnt_d  = '0;
                phase_d = (phase_q == PH_VISIBLE) ? PH_HIDDEN : PH_VISIBLE;
            end else begin
                bcnt_d = bcnt_q + BF_W'(1);
            end
        end
    end

    // Blink is qualified live so dropping it restores the pins on the next edge.
    assign hide = blink & (phase_q == PH_HIDDEN);

    assign cur_digit = snap[idx];

    bcd_to_7seg u_dec (
        .bcd (cur_digit),
        .seg (dec_seg)
    );

    // Active-high pin images for the current slot; the anode stays in the scan even when blanked.
    always_comb begin
        blank  = BLANK_LZ && (idx == IDX_LAST) && (snap[DIGITS-1] == 4'd0);
        seg_ah = (hide || blank) ? SEG_OFF : dec_seg;
        an_ah  = hide ? 4'b0000 : (4'b0001 << idx);
        dp_ah  = !hide && (idx == 2'd2) && colon_en;
    end

    // Output register; polarity is applied here only, so all internal logic stays active-high.
    always_ff @(posedge clock) begin
        if (reset) begin
            seg <= {7{ACTIVE_LOW}};
            dp  <= ACTIVE_LOW;
            an  <= {4{ACTIVE_LOW}};
        end else begin
            seg <= seg_ah ^ {7{ACTIVE_LOW}};
            dp  <= dp_ah ^ ACTIVE_LOW;
            an  <= an_ah ^ {4{ACTIVE_LOW}};
        end
    end

endmodule

// File: tb/tb_timer_display_scan.sv
// Self-checking bench for timer_display_scan (DIV=4, BLINK_FRAMES=2, active-low).
// The reference model works from the elapsed cycle count since reset release
// and a count of blinking frames, rather than from counters and phase flags.
module tb_timer_display_scan;

    localparam int DIV       = 4;
    localparam int BF        = 2;
    localparam int FRAME_CYC = 4 * DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] dig0, dig1, dig2, dig3;
    logic       colon_en, blink;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       frame;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state.
    int         m_n;        // edges since reset release
    logic [3:0] m_snap [4];
    int         m_bframes;  // frame pulses seen since blink last went low

    typedef struct {
        logic [3:0] val;
        logic [6:0] seg_exp;
    } dec_vec_t;
    dec_vec_t dec_tab [16];

    // Clock and reset block.
    always #5 clk = ~clk;

    timer_display_scan #(
        .DIV          (DIV),
        .BLINK_FRAMES (BF),
        .ACTIVE_LOW   (1'b1),
        .BLANK_LZ     (1'b1)
    ) dut (
        .clock    (clk),
        .reset    (rst),
        .dig0     (dig0),
        .dig1     (dig1),
        .dig2     (dig2),
        .dig3     (dig3),
        .colon_en (colon_en),
        .blink    (blink),
        .seg      (seg),
        .dp       (dp),
        .an       (an),
        .frame    (frame)
    );

    // Active-low glyphs written directly from the board segment chart.
    function automatic logic [6:0] glyph_al(input logic [3:0] v);
        case (v)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_n       = 0;
        m_bframes = 0;
        for (int i = 0; i < 4; i++) m_snap[i] = 4'd0;
    endtask

    // One clock: check frame before the edge, pins after it, then advance the model.
    task automatic step();
        int         idx;
        bit         fr, hid;
        logic [6:0] es;
        logic [3:0] ea;
        logic       ed;
        @(negedge clk);
        idx = (m_n / DIV) % 4;
        fr  = (m_n == 0) || ((m_n % FRAME_CYC) == FRAME_CYC - 1);
        check("frame", {31'd0, frame}, {31'd0, fr});
        hid = blink && (((m_bframes / BF) % 2) == 1);
        if (hid || (idx == 3 && m_snap[3] == 4'd0)) es = 7'h7F;
        else es = glyph_al(m_snap[idx]);
        ea = hid ? 4'hF : ~(4'b0001 << idx);
        ed = !(!hid && idx == 2 && colon_en);
        if (fr) begin
            m_snap[0] = dig0; m_snap[1] = dig1; m_snap[2] = dig2; m_snap[3] = dig3;
        end
        m_bframes = blink ? m_bframes + (fr ? 1 : 0) : 0;
        @(posedge clk);
        #1;
        check("seg", {25'd0, seg}, {25'd0, es});
        check("an", {28'd0, an}, {28'd0, ea});
        check("dp", {31'd0, dp}, {31'd0, ed});
        m_n++;
    endtask

    // Step until the given anode pattern is on the pins, bounded to a few frames.
    task automatic wait_an(input logic [3:0] target);
        int i = 0;
        while (an !== target && i < 3 * FRAME_CYC) begin
            step();
            i++;
        end
        check("wait_an", {28'd0, an}, {28'd0, target});
    endtask

    task automatic check_reset_pins();
        check("rst_seg", {25'd0, seg}, 32'h7F);
        check("rst_dp", {31'd0, dp}, 32'h1);
        check("rst_an", {28'd0, an}, 32'hF);
    endtask

    initial begin
        int run, longest, dp_bad, dp_on;
        logic [6:0] walk_seg [4];
        logic [3:0] walk_an [4];

        for (int v = 0; v < 16; v++) begin
            dec_tab[v].val     = 4'(v);
            dec_tab[v].seg_exp = glyph_al(4'(v));
        end
        walk_an[0] = 4'hE; walk_an[1] = 4'hD; walk_an[2] = 4'hB; walk_an[3] = 4'h7;
        walk_seg[0] = 7'h12; walk_seg[1] = 7'h40; walk_seg[2] = 7'h40; walk_seg[3] = 7'h7F;

        rst = 1'b1; dig0 = 4'd0; dig1 = 4'd0; dig2 = 4'd0; dig3 = 4'd0;
        colon_en = 1'b0; blink = 1'b0;

        // Reset held three cycles.
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check_reset_pins();
            check("rst_frame", {31'd0, frame}, 32'h0);
        end

        // Release: frame in the first cycle, an=E in the second.
        rst = 1'b0;
        model_reset();
        step();
        check("rel_an", {28'd0, an}, 32'hE);

        // Digits 5,0,0,0 (dig0..dig3): walk E,D,B,7 with 4 cycles each, digit 3 blanked.
        dig0 = 4'd5; dig1 = 4'd0; dig2 = 4'd0; dig3 = 4'd0;
        repeat (2 * FRAME_CYC) step();
        wait_an(4'hE);
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < DIV; c++) begin
                check("walk_an", {28'd0, an}, {28'd0, walk_an[d]});
                check("walk_seg", {25'd0, seg}, {25'd0, walk_seg[d]});
                step();
            end
        end

        // Colon: dp low only while an=B.
        colon_en = 1'b1;
        step();
        dp_bad = 0; dp_on = 0;
        for (int c = 0; c < 2 * FRAME_CYC; c++) begin
            step();
            if (dp == 1'b0 && an != 4'hB) dp_bad++;
            if (dp == 1'b0 && an == 4'hB) dp_on++;
        end
        check("colon_stray", dp_bad, 0);
        check("colon_cycles", dp_on, 2 * DIV);

        // Decode table: every code on digit 0, including the dash for 10-15.
        for (int v = 0; v < 16; v++) begin
            dig0 = dec_tab[v].val;
            repeat (2 * FRAME_CYC) step();
            wait_an(4'hE);
            check("decode", {25'd0, seg}, {25'd0, dec_tab[v].seg_exp});
        end

        // Mid-frame change of dig2 is not shown until after the next frame pulse.
        dig2 = 4'd0;
        repeat (2 * FRAME_CYC) step();
        wait_an(4'hE);
        dig2 = 4'd8;
        wait_an(4'hB);
        check("tear_old", {25'd0, seg}, 32'h40);
        wait_an(4'hE);
        wait_an(4'hB);
        check("tear_new", {25'd0, seg}, 32'h00);

        // Blink: hidden runs last two frames.
        blink = 1'b1;
        run = 0; longest = 0;
        for (int c = 0; c < 100; c++) begin
            step();
            if (an == 4'hF) begin
                run++;
                if (run > longest) longest = run;
            end else begin
                run = 0;
            end
        end
        check("blink_hidden_len", longest, 2 * FRAME_CYC);

        // Drop blink while hidden: scanning back on the next cycle.
        wait_an(4'hF);
        step();
        blink = 1'b0;
        step();
        check("unblink_an", {31'd0, (an != 4'hF)}, 32'h1);

        // Reset mid-slot.
        wait_an(4'hD);
        step();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_pins();
        @(negedge clk);
        check("rst_mid_frame", {31'd0, frame}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0: dig0 = 4'($urandom_range(0, 15));
                    1: dig1 = 4'($urandom_range(0, 15));
                    2: dig2 = 4'($urandom_range(0, 15));
                    default: dig3 = 4'($urandom_range(0, 15));
                endcase
            end
            if ($urandom_range(0, 15) == 0) colon_en = ~colon_en;
            if ($urandom_range(0, 63) == 0) blink = ~blink;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
